// File: rtl/sng_pkg.sv
// ============================================================================
//  Module   : sng_pkg
//  Purpose  : Shared constants, state type and tap-mask helper for the
//             stochastic number generator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sng_pkg;

   // Feedback tap masks (bit i set = bit i participates in the XOR).
   localparam logic [7:0]  TAPS8  = 8'hB8;    // bits 7,5,4,3
   localparam logic [15:0] TAPS16 = 16'hD008; // bits 15,14,12,3

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Tap mask for a supported width, zero-extended to 16 bits.
   function automatic logic [15:0] tap_mask(input int n);
      if (n == 16) return TAPS16;
      return {8'h00, TAPS8};
   endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_fib.sv
// ============================================================================
//  Module   : lfsr_fib
//  Purpose  : Fibonacci LFSR, left shift, feedback = XOR of tapped bits.
//             LOAD has priority over STEP.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_fib
   import sng_pkg::*;
#(
   parameter int             N    = 8,
   parameter logic [N-1:0]   TAPS = N'(tap_mask(N))
) (
   input  logic         CLK,
   input  logic         RSTN,
   input  logic         LOAD,
   input  logic [N-1:0] SEED,
   input  logic         STEP,
   output logic [N-1:0] Q
);

   // Shift register: clear on reset, load seed, or advance one step.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         Q <= '0;
      end else if (LOAD) begin
         Q <= SEED;
      end else if (STEP) begin
         Q <= {Q[N-2:0], ^(Q & TAPS)};
      end
   end

endmodule

`default_nettype wire

// File: rtl/stoch_num_gen.sv
// ============================================================================
//  Module   : stoch_num_gen
//  Purpose  : Converts an N-bit unsigned value into a temporal stochastic
//             bitstream of LEN bits: OUT = (lfsr < value) each RUN cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stoch_num_gen
   import sng_pkg::*;
#(
   parameter int N    = 8,
   parameter int LENW = 16
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic            START,
   input  logic [N-1:0]    VAL,
   input  logic [N-1:0]    SEED,
   input  logic [LENW-1:0] LEN,
   output logic            OUT,
   output logic            VALID,
   output logic            BUSY,
   output logic            DONE
);

   generate
      if (N != 8 && N != 16) begin : g_bad_n
         $error("stoch_num_gen: N must be 8 or 16");
      end
   endgenerate

   localparam logic [N-1:0]    TAPS    = N'(tap_mask(N));
   localparam logic [LENW-1:0] CNT_ONE = LENW'(1);

   state_t            state;
   logic [N-1:0]      val_q;
   logic [LENW-1:0]   cnt;
   logic [N-1:0]      lfsr;
   logic [N-1:0]      seed_eff;
   logic              load;
   logic              step;

   // All-zero is the LFSR lock-up state, so a zero seed becomes all-ones.
   assign seed_eff = (SEED == '0) ? '1 : SEED;
   assign load     = (state == IDLE) && START;
   assign step     = (state == RUN);

   lfsr_fib #(
      .N    (N),
      .TAPS (TAPS)
   ) u_lfsr (
      .CLK  (CLK),
      .RSTN (RSTN),
      .LOAD (load),
      .SEED (seed_eff),
      .STEP (step),
      .Q    (lfsr)
   );

   // Control FSM with length counter and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state <= IDLE;
         val_q <= '0;
         cnt   <= '0;
         OUT   <= 1'b0;
         VALID <= 1'b0;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               OUT   <= 1'b0;
               VALID <= 1'b0;
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               if (START) begin
                  val_q <= VAL;
                  cnt   <= LEN;
                  BUSY  <= 1'b1;
                  state <= (LEN != '0) ? RUN : FIN;
               end
            end
            RUN: begin
               OUT   <= (lfsr < val_q);
               VALID <= 1'b1;
               BUSY  <= 1'b1;
               DONE  <= 1'b0;
               cnt   <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) state <= FIN;
            end
            FIN: begin
               OUT   <= 1'b0;
               VALID <= 1'b0;
               BUSY  <= 1'b1;
               DONE  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               OUT   <= 1'b0;
               VALID <= 1'b0;
               BUSY  <= 1'b0;
               DONE  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
